// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues in-order word fetches to instruction memory,
// buffers returned words with their PCs, and hands them to the decoder over a
// valid/ready handshake. A one-cycle redirect flushes buffered and in-flight
// fetches and restarts at the target.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  // instruction memory port
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // decoder port
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instrm,
  output logic [31:0] inst_pc,
  // redirect port
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  entry_t           fifo_q [FIFO_DEPTH];

  logic [CNT_W:0]   in_use;
  logic [31:0]      redirect_aligned;
  logic             grant;
  logic             resp_fire;
  logic             enq;
  logic             deq;

  // Credit covers both buffered words and words still in flight, so every
  // response is guaranteed a free slot when it arrives.
  assign in_use           = {1'b0, count_q} + {1'b0, outstanding_q};
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  assign imem_req  = rstn && !redirect && (in_use < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp_fire = imem_rvalid && (outstanding_q != '0);
  assign enq       = resp_fire && (discard_q == '0) && !redirect;
  assign deq       = (count_q != '0) && inst_ready && !redirect;

  assign inst_valid = (count_q != '0);
  assign inst_pc    = fifo_q[rd_ptr_q].pc;
  assign instrm     = fifo_q[rd_ptr_q].instr;

  // Next-state logic for PCs, in-flight/discard counters and FIFO pointers.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect) begin
      // No grant is possible this cycle, so only an arriving response moves
      // the in-flight count; everything still in flight becomes stale.
      fetch_pc_d    = redirect_aligned;
      resp_pc_d     = redirect_aligned;
      outstanding_d = outstanding_q - CNT_W'(resp_fire);
      discard_d     = outstanding_q - CNT_W'(resp_fire);
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(resp_fire);
      if (resp_fire && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
      if (enq) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      end
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see
    // pre-edge values regardless of evaluation order.
    if (!rstn) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Instruction buffer storage, written with each kept response.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: this small buffer is reset because its head drives instrm/inst_pc
    // directly and those must read zero out of reset.
    if (!rstn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else if (enq) begin
      fifo_q[wr_ptr_q] <= {resp_pc_q, imem_rdata};
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch. A behavioural memory answers granted
// requests with random in-order latency; the reference model is simply the
// architectural PC stream: after reset or a redirect, the decoder must see
// consecutive word addresses with the memory contents at those addresses.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instrm;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  inst_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .instrm      (instrm),
    .inst_pc     (inst_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        rsp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_due = 0;
  int          nhs   = 0;
  int          ngrants = 0;
  logic [31:0] exp_pc;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = '0;

  // memory behaviour knobs
  logic        gnt_on   = 1'b1;
  logic        gnt_rand = 1'b0;
  int          gnt_left = -1;
  int          lat_min  = 1;
  int          lat_max  = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock cycle: drive memory inputs, check the cycle's outputs against
  // the PC-stream model, then advance to the next falling edge.
  task automatic step();
    logic rv;
    int   lat;
    int   due;
    imem_gnt    = gnt_on && (gnt_left != 0) &&
                  (gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    rv          = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(rsp_q[0].addr) : $urandom;
    #1;
    total++;
    if (imem_addr[1:0] !== 2'b00) begin
      bad++;
      $display("FAIL addr_align: got %h want low bits 00", imem_addr);
    end
    if (prev_stall && !redirect) begin
      total++;
      if (imem_addr !== prev_addr) begin
        bad++;
        $display("FAIL addr_stable: got %h want %h", imem_addr, prev_addr);
      end
    end
    if (redirect) begin
      total++;
      if (imem_req !== 1'b0) begin
        bad++;
        $display("FAIL req_in_redirect: got %b want 0", imem_req);
      end
    end
    if (inst_valid && inst_ready && !redirect) begin
      total++;
      if (inst_pc !== exp_pc || instrm !== mem_word(exp_pc)) begin
        bad++;
        $display("FAIL pc_stream: got pc=%h instr=%h want pc=%h instr=%h",
                 inst_pc, instrm, exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      nhs++;
    end
    if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
    if (imem_req && imem_gnt) begin
      lat = $urandom_range(lat_min, lat_max);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rsp_q.push_back('{addr: imem_addr, due: due});
      ngrants++;
      if (gnt_left > 0) gnt_left--;
    end
    if (rv) void'(rsp_q.pop_front());
    prev_stall = imem_req && !imem_gnt && !redirect;
    prev_addr  = imem_addr;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Assert reset (asynchronously, from wherever we are), check reset outputs,
  // and release on a falling edge.
  task automatic apply_reset();
    rstn        = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got req=%b valid=%b want 0 0", imem_req, inst_valid);
    end
    total++;
    if (inst_pc !== 32'h0 || instrm !== 32'h0 || imem_addr !== RESET_PC) begin
      bad++;
      $display("FAIL reset_data: got pc=%h instr=%h addr=%h want 0 0 %h",
               inst_pc, instrm, imem_addr, RESET_PC);
    end
    rsp_q.delete();
    prev_stall = 1'b0;
    exp_pc     = RESET_PC;
    last_due   = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Pulse redirect for one cycle and check the two dead cycles that follow.
  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    step();
    redirect    = 1'b0;
    redirect_pc = $urandom;
    total++;
    if (inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL redirect_r1_valid: got %b want 0", inst_valid);
    end
    step();
    total++;
    if (inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL redirect_r2_valid: got %b want 0", inst_valid);
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_straight_line();
    int first = -1;
    int hs0;
    gnt_on = 1'b1; gnt_rand = 1'b0; gnt_left = -1;
    lat_min = 1; lat_max = 1; inst_ready = 1'b1;
    hs0 = nhs;
    for (int i = 0; i < 32; i++) begin
      if (inst_valid && first < 0) first = i;
      step();
    end
    total++;
    if (first != 2) begin
      bad++;
      $display("FAIL first_valid_cycle: got %0d want 2", first);
    end
    total++;
    if (nhs - hs0 != 30) begin
      bad++;
      $display("FAIL throughput: got %0d want 30", nhs - hs0);
    end
  endtask

  task automatic test_backpressure();
    int hs0;
    inst_ready = 1'b0;
    repeat (12) step();
    total++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_stall: got req=%b valid=%b want 0 1", imem_req, inst_valid);
    end
    // drain with no new grants: exactly a full buffer must come out
    gnt_on = 1'b0; inst_ready = 1'b1;
    hs0 = nhs;
    repeat (10) step();
    total++;
    if (nhs - hs0 != DEPTH) begin
      bad++;
      $display("FAIL bp_buffered: got %0d want %0d", nhs - hs0, DEPTH);
    end
    gnt_on = 1'b1;
    hs0 = nhs;
    repeat (20) step();
    total++;
    if (nhs - hs0 < 15) begin
      bad++;
      $display("FAIL bp_resume: got %0d want >=15", nhs - hs0);
    end
  endtask

  task automatic test_grant_stalls();
    int hs0;
    gnt_rand = 1'b1; lat_min = 1; lat_max = 3;
    hs0 = nhs;
    for (int i = 0; i < 400; i++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) do_redirect($urandom);
      else step();
    end
    total++;
    if (nhs - hs0 < 40) begin
      bad++;
      $display("FAIL random_progress: got %0d want >=40", nhs - hs0);
    end
    gnt_rand = 1'b0; inst_ready = 1'b1; lat_min = 1; lat_max = 1;
  endtask

  task automatic test_redirect_inflight();
    int n;
    lat_min = 3; lat_max = 3; inst_ready = 1'b1;
    repeat (10) step();
    total++;
    if (rsp_q.size() < 2) begin
      bad++;
      $display("FAIL inflight_setup: got %0d want >=2", rsp_q.size());
    end
    do_redirect(32'h0000_0100);
    n = 0;
    while (!inst_valid && n < 20) begin
      step();
      n++;
    end
    total++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_0100) begin
      bad++;
      $display("FAIL redirect_target: got valid=%b pc=%h want 1 00000100",
               inst_valid, inst_pc);
    end
    repeat (10) step();
    lat_min = 1; lat_max = 1;
  endtask

  task automatic test_redirect_same_cycle();
    inst_ready = 1'b1;
    repeat (8) step();
    total++;
    if (!(inst_valid && rsp_q.size() > 0 && rsp_q[0].due <= cyc)) begin
      bad++;
      $display("FAIL same_cycle_setup: got valid=%b pending=%0d want 1 >0",
               inst_valid, rsp_q.size());
    end
    do_redirect(32'h0000_0203);
    step();
    total++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_0200 ||
        instrm !== mem_word(32'h0000_0200)) begin
      bad++;
      $display("FAIL same_cycle_r3: got valid=%b pc=%h instr=%h want 1 00000200 %h",
               inst_valid, inst_pc, instrm, mem_word(32'h0000_0200));
    end
    repeat (10) step();
  endtask

  task automatic test_pc_wrap();
    int hs0;
    do_redirect(32'hFFFF_FFF5);
    hs0 = nhs;
    repeat (10) step();
    total++;
    if (nhs - hs0 < 6) begin
      bad++;
      $display("FAIL wrap_progress: got %0d want >=6", nhs - hs0);
    end
  endtask

  task automatic test_reset_midstream();
    int g0;
    int hs0;
    inst_ready = 1'b0;
    gnt_left   = 3;
    g0 = ngrants;
    do_redirect(32'h0000_0300);
    repeat (4) step();
    total++;
    if (ngrants - g0 != 3 || inst_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_setup: got grants=%0d valid=%b want 3 1",
               ngrants - g0, inst_valid);
    end
    gnt_left = -1;
    #2;
    apply_reset();
    inst_ready = 1'b1;
    hs0 = nhs;
    repeat (20) step();
    total++;
    if (nhs - hs0 < 15) begin
      bad++;
      $display("FAIL post_reset_stream: got %0d want >=15", nhs - hs0);
    end
  endtask

  initial begin
    rstn        = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    exp_pc      = RESET_PC;
    @(negedge clk);
    test_reset();
    test_straight_line();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_pc_wrap();
    test_grant_stalls();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
